// File: rtl/hi_xcorr_ssp_tx_pkg.sv
// Shared definitions for the xcorr SSP transmitter: word width, FSM states, {I,Q} packing.
package hi_xcorr_ssp_tx_pkg;

  localparam int SSP_WORD_W = 16;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  function automatic logic [SSP_WORD_W-1:0] pack_word(input logic [7:0] i, input logic [7:0] q);
    return {i, q};
  endfunction

endpackage

// File: rtl/hi_xcorr_ssp_tx_fifo.sv
// hi_ssp_fifo: small synchronous FIFO; pointers wrap naturally, so DEPTH must be a power of 2.
module hi_ssp_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [AW:0]      o_level
);

  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_level;
  logic             w_wr_en;
  logic             w_rd_en;

  assign o_full    = (r_level == FULL_LVL);
  assign o_empty   = (r_level == '0);
  assign o_level   = r_level;
  assign o_rd_data = r_mem[r_rd_ptr];

  // A push while full is only taken when the same cycle frees a slot.
  assign w_rd_en = i_pop && !o_empty;
  assign w_wr_en = i_push && (!o_full || w_rd_en);

  always_ff @(posedge i_clk) begin
    if (w_wr_en) r_mem[r_wr_ptr] <= i_wr_data;
  end

  always_ff @(posedge i_clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr_en, w_rd_en})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/hi_xcorr_ssp_tx.sv
// Buffers (I,Q) correlation pairs and shifts each out as a 16-bit {I,Q} SSP word, MSB first.
// Define HI_SSP_TX_OVERFLOW_EN to add the sticky overflow flag and saturating drop_cnt ports.
module hi_xcorr_ssp_tx
  import hi_xcorr_ssp_tx_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CLK_DIV    = 2
) (
  input  logic                          ck_1356meg,
  input  logic                          rst_n,
  input  logic                          pair_valid,
  input  logic [7:0]                    corr_i,
  input  logic [7:0]                    corr_q,
  output logic                          ssp_clk,
  output logic                          ssp_frame,
  output logic                          ssp_din,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          dbg
`ifdef HI_SSP_TX_OVERFLOW_EN
  ,
  output logic                          overflow,
  output logic [7:0]                    drop_cnt
`endif
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(SSP_WORD_W);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(SSP_WORD_W - 1);

  state_t                  r_state, w_state_nxt;
  logic [SSP_WORD_W-1:0]   r_shift, w_shift_nxt;
  logic [BIT_W-1:0]        r_bit_cnt, w_bit_cnt_nxt;
  logic [DIV_W-1:0]        r_div_cnt, w_div_cnt_nxt;
  logic                    r_ssp_clk, w_ssp_clk_nxt;
  logic                    r_frame, w_frame_nxt;
  logic                    r_din, w_din_nxt;
  logic                    w_pop;
  logic                    w_push;
  logic                    w_full;
  logic                    w_empty;
  logic                    w_wrap;
  logic [SSP_WORD_W-1:0]   w_fifo_word;

  assign w_push = pair_valid && (!w_full || w_pop);

  hi_ssp_fifo #(
    .WIDTH (SSP_WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk     (ck_1356meg),
    .rst_n     (rst_n),
    .i_push    (w_push),
    .i_wr_data (pack_word(corr_i, corr_q)),
    .i_pop     (w_pop),
    .o_rd_data (w_fifo_word),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_level   (fifo_level)
  );

  assign ssp_clk   = r_ssp_clk;
  assign ssp_frame = r_frame;
  assign ssp_din   = r_din;
  assign dbg       = (r_state == ST_SHIFT);
  assign w_wrap    = (r_div_cnt == DIV_LAST);

  always_ff @(posedge ck_1356meg) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_shift_nxt   = r_shift;
    w_bit_cnt_nxt = r_bit_cnt;
    w_div_cnt_nxt = r_div_cnt;
    w_ssp_clk_nxt = r_ssp_clk;
    w_frame_nxt   = r_frame;
    w_din_nxt     = r_din;
    w_pop         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop         = 1'b1;
          w_shift_nxt   = w_fifo_word;
          w_bit_cnt_nxt = '0;
          w_div_cnt_nxt = '0;
          w_ssp_clk_nxt = 1'b0;
          w_frame_nxt   = 1'b1;
          w_din_nxt     = w_fifo_word[SSP_WORD_W-1];
          w_state_nxt   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        w_div_cnt_nxt = w_wrap ? '0 : r_div_cnt + 1'b1;
        // Data moves only on the falling toggle so the ARM sees it stable at the rising edge.
        if (w_wrap) begin
          w_ssp_clk_nxt = !r_ssp_clk;
          if (r_ssp_clk) begin
            w_frame_nxt = 1'b0;
            if (r_bit_cnt == BIT_LAST) begin
              w_din_nxt   = 1'b0;
              w_state_nxt = ST_IDLE;
            end else begin
              w_bit_cnt_nxt = r_bit_cnt + 1'b1;
              w_shift_nxt   = r_shift << 1;
              w_din_nxt     = r_shift[SSP_WORD_W-2];
            end
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge ck_1356meg) begin
    if (!rst_n) begin
      r_ssp_clk <= 1'b0;
      r_frame   <= 1'b0;
      r_din     <= 1'b0;
      r_bit_cnt <= '0;
      r_div_cnt <= '0;
    end else begin
      r_ssp_clk <= w_ssp_clk_nxt;
      r_frame   <= w_frame_nxt;
      r_din     <= w_din_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_div_cnt <= w_div_cnt_nxt;
    end
  end

  always_ff @(posedge ck_1356meg) begin
    r_shift <= w_shift_nxt;
  end

`ifdef HI_SSP_TX_OVERFLOW_EN
  logic       w_drop;
  logic       r_overflow;
  logic [7:0] r_drop_cnt;

  assign w_drop   = pair_valid && !w_push;
  assign overflow = r_overflow;
  assign drop_cnt = r_drop_cnt;

  always_ff @(posedge ck_1356meg) begin
    if (!rst_n) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_hi_xcorr_ssp_tx.sv
// Bench for hi_xcorr_ssp_tx: two instances (CLK_DIV=2 and CLK_DIV=1) checked against a queue model.
module tb_hi_xcorr_ssp_tx;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       pv0, pv1;
  logic [7:0] ci0, cq0, ci1, cq1;
  logic       sclk0, fr0, din0, dbg0;
  logic       sclk1, fr1, din1, dbg1;
  logic [2:0] lvl0, lvl1;
`ifdef HI_SSP_TX_OVERFLOW_EN
  logic       ovf0, ovf1;
  logic [7:0] dc0, dc1;
`endif

  hi_xcorr_ssp_tx #(.FIFO_DEPTH(DEPTH), .CLK_DIV(2)) u_dut0 (
    .ck_1356meg(clk), .rst_n(rst_n), .pair_valid(pv0), .corr_i(ci0), .corr_q(cq0),
    .ssp_clk(sclk0), .ssp_frame(fr0), .ssp_din(din0), .fifo_level(lvl0), .dbg(dbg0)
`ifdef HI_SSP_TX_OVERFLOW_EN
    , .overflow(ovf0), .drop_cnt(dc0)
`endif
  );

  hi_xcorr_ssp_tx #(.FIFO_DEPTH(DEPTH), .CLK_DIV(1)) u_dut1 (
    .ck_1356meg(clk), .rst_n(rst_n), .pair_valid(pv1), .corr_i(ci1), .corr_q(cq1),
    .ssp_clk(sclk1), .ssp_frame(fr1), .ssp_din(din1), .fifo_level(lvl1), .dbg(dbg1)
`ifdef HI_SSP_TX_OVERFLOW_EN
    , .overflow(ovf1), .drop_cnt(dc1)
`endif
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, req, req, cyc);
    end
  endtask

  // Model: a queue of pending words plus, per instance, the phase (edges since the load edge)
  // of the word on the wire. Outputs follow directly from the phase.
  int          m_cd[2] = '{2, 1};
  logic [15:0] q0[$];
  logic [15:0] q1[$];
  bit          m_busy[2];
  int          m_phase[2];
  logic [15:0] m_word[2];
  int          m_drop[2];
  bit          m_init = 1'b0;

  function automatic int qsize(input int k);
    return (k == 0) ? q0.size() : q1.size();
  endfunction

  task automatic model_step();
    cyc++;
    if (!rst_n) begin
      m_init = 1'b1;
      q0.delete();
      q1.delete();
      for (int k = 0; k < 2; k++) begin
        m_busy[k] = 1'b0;
        m_phase[k] = 0;
        m_drop[k] = 0;
      end
      return;
    end
    for (int k = 0; k < 2; k++) begin
      logic        pv;
      logic [15:0] w;
      pv = (k == 0) ? pv0 : pv1;
      w  = (k == 0) ? {ci0, cq0} : {ci1, cq1};
      if (m_busy[k]) begin
        m_phase[k]++;
        if (m_phase[k] == 32 * m_cd[k]) m_busy[k] = 1'b0;
      end else if (qsize(k) > 0) begin
        m_word[k]  = (k == 0) ? q0.pop_front() : q1.pop_front();
        m_phase[k] = 0;
        m_busy[k]  = 1'b1;
      end
      if (pv) begin
        if (qsize(k) < DEPTH) begin
          if (k == 0) q0.push_back(w);
          else        q1.push_back(w);
        end else if (m_drop[k] < 255) begin
          m_drop[k]++;
        end
      end
    end
  endtask

  always @(posedge clk) model_step();

  // Compare process: every cycle after the first reset, all outputs of both instances.
  always @(negedge clk) begin
    if (m_init) begin
      for (int k = 0; k < 2; k++) begin
        int e_clk, e_fr, e_din, e_dbg, bitn;
        int a_clk, a_fr, a_din, a_dbg, a_lvl;
        bitn  = m_phase[k] / (2 * m_cd[k]);
        e_dbg = m_busy[k] ? 1 : 0;
        e_clk = (m_busy[k] && ((m_phase[k] / m_cd[k]) % 2 == 1)) ? 1 : 0;
        e_fr  = (m_busy[k] && (m_phase[k] < 2 * m_cd[k])) ? 1 : 0;
        e_din = (m_busy[k] && bitn < 16) ? int'(m_word[k][15 - bitn]) : 0;
        a_clk = int'((k == 0) ? sclk0 : sclk1);
        a_fr  = int'((k == 0) ? fr0 : fr1);
        a_din = int'((k == 0) ? din0 : din1);
        a_dbg = int'((k == 0) ? dbg0 : dbg1);
        a_lvl = int'((k == 0) ? lvl0 : lvl1);
        chk($sformatf("ssp_clk[%0d]", k), a_clk, e_clk);
        chk($sformatf("ssp_frame[%0d]", k), a_fr, e_fr);
        chk($sformatf("ssp_din[%0d]", k), a_din, e_din);
        chk($sformatf("dbg[%0d]", k), a_dbg, e_dbg);
        chk($sformatf("fifo_level[%0d]", k), a_lvl, qsize(k));
`ifdef HI_SSP_TX_OVERFLOW_EN
        chk($sformatf("overflow[%0d]", k), int'((k == 0) ? ovf0 : ovf1), (m_drop[k] > 0) ? 1 : 0);
        chk($sformatf("drop_cnt[%0d]", k), int'((k == 0) ? dc0 : dc1), m_drop[k]);
`endif
      end
    end
  end

  // ARM-side receiver: samples ssp_din on rising ssp_clk, logs words, frame rise times and widths.
  logic        p_clk[2]  = '{1'b0, 1'b0};
  logic        p_fr[2]   = '{1'b0, 1'b0};
  logic [15:0] rx_sr[2]  = '{16'h0, 16'h0};
  int          rx_n[2]   = '{0, 0};
  int          fw_cnt[2] = '{0, 0};
  logic [15:0] rx0[$];
  logic [15:0] rx1[$];
  int          frt0[$];
  int          frt1[$];
  int          fw0[$];
  int          fw1[$];
  int          peak0 = 0;

  task automatic mon(input int k, input logic c, input logic f, input logic d);
    if (!rst_n) begin
      rx_n[k] = 0;
      p_clk[k] = 1'b0;
      p_fr[k] = 1'b0;
      fw_cnt[k] = 0;
      return;
    end
    if (c && !p_clk[k]) begin
      rx_sr[k] = {rx_sr[k][14:0], d};
      rx_n[k]++;
      if (rx_n[k] == 16) begin
        rx_n[k] = 0;
        if (k == 0) rx0.push_back(rx_sr[k]);
        else        rx1.push_back(rx_sr[k]);
      end
    end
    if (f && !p_fr[k]) begin
      if (k == 0) frt0.push_back(cyc);
      else        frt1.push_back(cyc);
      fw_cnt[k] = 0;
    end
    if (f) fw_cnt[k]++;
    else if (p_fr[k]) begin
      if (k == 0) fw0.push_back(fw_cnt[k]);
      else        fw1.push_back(fw_cnt[k]);
    end
    p_clk[k] = c;
    p_fr[k]  = f;
  endtask

  always @(negedge clk) begin
    mon(0, sclk0, fr0, din0);
    mon(1, sclk1, fr1, din1);
    if (rst_n && int'(lvl0) > peak0) peak0 = int'(lvl0);
  end

  function automatic int qget(input int k, input int idx);
    if (k == 0) return (idx < rx0.size()) ? int'(rx0[idx]) : -1;
    return (idx < rx1.size()) ? int'(rx1[idx]) : -1;
  endfunction

  function automatic int tget(input int k, input int idx);
    if (k == 0) return (idx < frt0.size()) ? frt0[idx] : -1000;
    return (idx < frt1.size()) ? frt1[idx] : -1000;
  endfunction

  function automatic int wget(input int k, input int idx);
    if (k == 0) return (idx < fw0.size()) ? fw0[idx] : -1;
    return (idx < fw1.size()) ? fw1[idx] : -1;
  endfunction

  int t_strobe0, t_strobe1;

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic strobe0(input logic [7:0] i, input logic [7:0] q);
    pv0 = 1'b1; ci0 = i; cq0 = q; t_strobe0 = cyc;
    tick();
    pv0 = 1'b0;
  endtask

  task automatic strobe1(input logic [7:0] i, input logic [7:0] q);
    pv1 = 1'b1; ci1 = i; cq1 = q; t_strobe1 = cyc;
    tick();
    pv1 = 1'b0;
  endtask

  logic [15:0] exp_t3[6] = '{16'hA001, 16'hA002, 16'hA003, 16'hA004, 16'hA005, 16'hB007};

  initial begin
    rst_n = 1'b0;
    pv0 = 1'b0; ci0 = 8'h00; cq0 = 8'h00;
    pv1 = 1'b0; ci1 = 8'h00; cq1 = 8'h00;
    tick(3);
    chk("reset_ssp_clk", int'(sclk0), 0);
    chk("reset_frame", int'(fr0), 0);
    chk("reset_din", int'(din0), 0);
    chk("reset_dbg", int'(dbg0), 0);
    chk("reset_level", int'(lvl0), 0);
    rst_n = 1'b1;
    tick(2);

    // Single word, CLK_DIV=2
    strobe0(8'h5A, 8'hC3);
    tick(80);
    chk("t1_nwords", rx0.size(), 1);
    chk("t1_word", qget(0, 0), 16'h5AC3);
    chk("t1_latency", tget(0, 0) - t_strobe0, 2);
    chk("t1_frame_w", wget(0, 0), 4);

    // Back-to-back strobes
    peak0 = 0;
    strobe0(8'h11, 8'h22);
    strobe0(8'h33, 8'h44);
    strobe0(8'h55, 8'h66);
    tick(3 * 65 + 10);
    chk("t2_nwords", rx0.size(), 4);
    chk("t2_word0", qget(0, 1), 16'h1122);
    chk("t2_word1", qget(0, 2), 16'h3344);
    chk("t2_word2", qget(0, 3), 16'h5566);
    chk("t2_period_a", tget(0, 2) - tget(0, 1), 65);
    chk("t2_period_b", tget(0, 3) - tget(0, 2), 65);
    chk("t2_level_peak", peak0, 2);

    // Overflow, then a strobe on the pop edge while full
    for (int n = 1; n <= 6; n++) strobe0(8'hA0, 8'(n));
    chk("t3_level_full", int'(lvl0), 4);
    for (int n = 0; n < 200 && dbg0; n++) tick();
    chk("t3_reach_idle", int'(dbg0), 0);
    chk("t4_level_before", int'(lvl0), 4);
    strobe0(8'hB0, 8'h07);
    chk("t4_level_after", int'(lvl0), 4);
`ifdef HI_SSP_TX_OVERFLOW_EN
    chk("t3_overflow", int'(ovf0), 1);
    chk("t3_drop_cnt", int'(dc0), 1);
`endif
    tick(6 * 65 + 10);
    chk("t3_nwords", rx0.size(), 10);
    for (int n = 0; n < 6; n++) chk($sformatf("t3_word%0d", n), qget(0, 4 + n), int'(exp_t3[n]));

    // Reset in the middle of bit 7, with a second pair still queued
    strobe0(8'hC1, 8'hC1);
    strobe0(8'h01, 8'h02);
    tick(30);
    chk("t5_pre_level", int'(lvl0), 1);
    chk("t5_pre_clk", int'(sclk0), 1);
    rst_n = 1'b0;
    tick();
    chk("t5_rst_clk", int'(sclk0), 0);
    chk("t5_rst_frame", int'(fr0), 0);
    chk("t5_rst_din", int'(din0), 0);
    chk("t5_rst_dbg", int'(dbg0), 0);
    chk("t5_rst_level", int'(lvl0), 0);
`ifdef HI_SSP_TX_OVERFLOW_EN
    chk("t5_rst_overflow", int'(ovf0), 0);
    chk("t5_rst_drop_cnt", int'(dc0), 0);
`endif
    rst_n = 1'b1;
    tick(2);
    strobe0(8'h01, 8'h80);
    tick(80);
    chk("t5_nwords", rx0.size(), 11);
    chk("t5_word", qget(0, 10), 16'h0180);

    // CLK_DIV=1 instance
    strobe1(8'hFF, 8'h00);
    strobe1(8'h12, 8'h34);
    tick(80);
    chk("t6_nwords", rx1.size(), 2);
    chk("t6_word0", qget(1, 0), 16'hFF00);
    chk("t6_word1", qget(1, 1), 16'h1234);
    chk("t6_period", tget(1, 1) - tget(1, 0), 33);
    chk("t6_frame_w", wget(1, 0), 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
